// File: rtl/digital_design_pkg.sv
`default_nettype none
// ============================================================================
// Package     : digital_design_pkg
// Description : Items shared by the switch-level OR gate cell and its
//               wrapper: the number of two-input combinations and the
//               coverage vector type indexed by {a,b}.
// Revision    : 1.0 - initial release
// ============================================================================
package digital_design_pkg;

  // Number of distinct {a,b} input combinations of a two-input gate.
  localparam int OR_COMBOS = 4;

  // One sticky bit per {a,b} combination; bit index is {a,b}.
  typedef logic [OR_COMBOS-1:0] combo_vec_t;

endpackage : digital_design_pkg
`default_nettype wire

// File: rtl/or_gate_cmos.sv
`default_nettype none
// ============================================================================
// Module      : or_gate_cmos
// Description : Two-input OR gate at switch level: a CMOS NOR stage
//               followed by a CMOS inverter, six transistors in total.
//               No clock; purely combinational.
// Ports       : a   - operand A
//               b   - operand B
//               out - a | b as resolved by the transistor network
// Revision    : 1.0 - initial release
// ============================================================================
module or_gate_cmos (
  input  logic a,
  input  logic b,
  output logic out
);

`ifdef SYNTHESIS
  // Transistor primitives are a simulation model only; synthesis gets the
  // equivalent Boolean function.
  assign out = a | b;
`else
  supply1 vdd;
  supply0 gnd;

  wire pu_mid;   // node between the two series pull-up devices
  wire nor_n;    // NOR output, input to the inverter
  wire out_sw;   // inverter output node

  // NOR pull-up: series pmos chain, conducts only when a = 0 and b = 0.
  pmos p_a   (pu_mid, vdd,    a);
  pmos p_b   (nor_n,  pu_mid, b);

  // NOR pull-down: parallel nmos pair, either input high pulls low.
  nmos n_a   (nor_n,  gnd,    a);
  nmos n_b   (nor_n,  gnd,    b);

  // Output inverter restores the OR polarity.
  pmos p_inv (out_sw, vdd,    nor_n);
  nmos n_inv (out_sw, gnd,    nor_n);

  // Hand the resolved switch-level value to the port unchanged; X/Z
  // results from unknown inputs pass through without masking.
  assign out = out_sw;
`endif

endmodule : or_gate_cmos
`default_nettype wire

// File: rtl/or_gate_sl.sv
`default_nettype none
// ============================================================================
// Module      : or_gate_sl
// Description : Switch-level two-input OR gate with a registered copy of
//               the output, sticky truth-table coverage and a sticky
//               self-check flag comparing the transistor network against
//               the behavioural a | b.
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset (clocked outputs)
//               a, b     - operands
//               out      - combinational a | b from the transistor core
//               out_q    - out registered on clk
//               seen     - sticky coverage, bit {a,b} set once sampled
//               mismatch - sticky, set when out differs from a | b at an
//                          edge with known inputs
// Revision    : 1.0 - initial release
// ============================================================================
module or_gate_sl
  import digital_design_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  output logic       out,
  output logic       out_q,
  output combo_vec_t seen,
  output logic       mismatch
);

  logic       core_out;
  logic       inputs_known;
  logic [1:0] combo;
  logic       behav_out;
  logic       core_differs;

  or_gate_cmos u_core (
    .a   (a),
    .b   (b),
    .out (core_out)
  );

  // The primary function: reset never touches the combinational path.
  assign out = core_out;

  // Coverage and checking only act on clean 0/1 inputs; an X or Z operand
  // must neither mark a combination as seen nor raise a false mismatch.
  assign inputs_known = !$isunknown({a, b});
  assign combo        = {a, b};
  assign behav_out    = a | b;
  // Case inequality so an X/Z produced by the core counts as a difference.
  assign core_differs = (core_out !== behav_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= 1'b0;
      seen     <= '0;
      mismatch <= 1'b0;
    end else begin
      out_q <= core_out;
      if (inputs_known) begin
        seen[combo] <= 1'b1;
        if (core_differs) begin
          mismatch <= 1'b1;
        end
      end
    end
  end

endmodule : or_gate_sl
`default_nettype wire

// File: tb/tb_or_gate_sl.sv
`default_nettype none
// ============================================================================
// Module      : tb_or_gate_sl
// Description : Self-checking bench for or_gate_sl. Each stimulus step
//               checks the combinational output directly and pushes the
//               hand-computed clocked response into a queue; a monitor
//               pops and compares it just after the following edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or_gate_sl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a   = 1'b0;
  logic       b   = 1'b0;
  logic       out;
  logic       out_q;
  logic [3:0] seen;
  logic       mismatch;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         step;
    logic       chk_q;   // 0 when out_q is legitimately unknown
    logic       q;
    logic [3:0] seen;
    logic       mm;
  } exp_t;

  exp_t exp_q[$];
  int   step_no = 0;
  bit   x_ok;

  or_gate_sl dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .out      (out),
    .out_q    (out_q),
    .seen     (seen),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step=%0d actual=%b required=%b", name, step_no, act, req);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step=%0d actual=%b required=%b", name, step_no, act, req);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check out, and queue
  // the clocked response expected after the next rising edge.
  task automatic step(input logic r, input logic va, input logic vb,
                      input logic exp_out, input logic chk_out,
                      input logic chk_q, input logic q,
                      input logic [3:0] sn, input logic mm);
    exp_t e;
    @(negedge clk);
    step_no++;
    rst = r;
    a   = va;
    b   = vb;
    #1;
    if (chk_out) check1("out", out, exp_out);
    e.step = step_no; e.chk_q = chk_q; e.q = q; e.seen = sn; e.mm = mm;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the clocked outputs shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_q) check1("out_q", out_q, e.q);
        check4("seen", seen, e.seen);
        check1("mismatch", mismatch, e.mm);
      end
    end
  end

  initial begin
    logic probe;
    exp_t e;
    probe = 1'bx;
    x_ok  = $isunknown(probe);

    // Reset cycle, then truth sweep 00, 10, 01, 11.
    //   r  a  b  out chk  chkq q  seen     mm
    step(1, 0, 0, 0,  1,   1,   0, 4'b0000, 0);
    step(0, 0, 0, 0,  1,   1,   0, 4'b0001, 0);
    step(0, 1, 0, 1,  1,   1,   1, 4'b0101, 0);
    step(0, 0, 1, 1,  1,   1,   1, 4'b0111, 0);
    step(0, 1, 1, 1,  1,   1,   1, 4'b1111, 0);

    // Reset clear: out keeps following a | b.
    step(1, 1, 1, 1,  1,   1,   0, 4'b0000, 0);

    // Partial coverage: only 00 and 11 across three edges.
    step(0, 0, 0, 0,  1,   1,   0, 4'b0001, 0);
    step(0, 1, 1, 1,  1,   1,   1, 4'b1001, 0);
    step(0, 0, 0, 0,  1,   1,   0, 4'b1001, 0);

    // Mid-cycle glitch on a with b = 0: only out sees the pulse.
    @(negedge clk);
    step_no++;
    a = 1'b1;
    #1 check1("glitch_out_high", out, 1'b1);
    #1 a = 1'b0;
    #1 check1("glitch_out_low", out, 1'b0);
    e.step = step_no; e.chk_q = 1'b1; e.q = 1'b0; e.seen = 4'b1001; e.mm = 1'b0;
    exp_q.push_back(e);

    // Unknown operand: only meaningful where the simulator keeps X.
    if (x_ok) begin
      step(0, 1'bx, 0, 0, 0,  0,   0, 4'b1001, 0);
      step(0, 1'bx, 1, 1, 1,  1,   1, 4'b1001, 0);
    end

    // Fault injection: core output stuck at 0 with ab = 11.
    @(negedge clk);
    step_no++;
    rst = 1'b0; a = 1'b1; b = 1'b1;
    force dut.core_out = 1'b0;
    #1 check1("forced_out", out, 1'b0);
    e.step = step_no; e.chk_q = 1'b1; e.q = 1'b0; e.seen = 4'b1001; e.mm = 1'b1;
    exp_q.push_back(e);

    @(negedge clk);
    release dut.core_out;
    step_no++;
    #1 check1("released_out", out, 1'b1);
    e.step = step_no; e.chk_q = 1'b1; e.q = 1'b1; e.seen = 4'b1001; e.mm = 1'b1;
    exp_q.push_back(e);

    step(0, 1, 1, 1,  1,   1,   1, 4'b1001, 1);
    step(1, 0, 1, 1,  1,   1,   0, 4'b0000, 0);
    step(0, 0, 1, 1,  1,   1,   1, 4'b0010, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the run is a few dozen cycles; anything far beyond is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_or_gate_sl
`default_nettype wire

// File: doc/or_gate_sl.md
# or_gate_sl

Two-input OR gate built at switch level (CMOS transistor primitives), with an optional registered copy of the output and a built-in truth-table coverage and self-check monitor. It is a teaching and characterisation leaf cell in the Day-004 switch-level modeling set. The combinational path is the primary function. The clocked logic only observes and registers it, so the block also drops into synchronous designs.

## Interface
- No parameters.
- `clk`  input  1  single clock, rising-edge active.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  1  operand A.
- `b`  input  1  operand B.
- `out`  output  1  combinational `a | b`, switch-level implementation.
- `out_q`  output  1  `out` registered on `clk`.
- `seen`  output  4  sticky coverage bits. Bit index is `{a,b}`; the bit is set once that input combination has been sampled.
- `mismatch`  output  1  sticky flag. Set when the switch-level `out` differs from the behavioural `a | b` at a clock edge.

## Operation
- Core structure: CMOS NOR followed by a CMOS inverter, 6 transistors total.
  - NOR pull-up: two `pmos` in series from `supply1`, gated by `a` and by `b`.
  - NOR pull-down: two `nmos` in parallel to `supply0`, gated by `a` and by `b`.
  - Inverter: one `pmos` and one `nmos` gated by the NOR node, driving `out`.
- Truth table: 00→0, 01→1, 10→1, 11→1.
- With X or Z on an input, `out` is whatever the primitives resolve to; it may be X. No masking is applied.
- Registered path: `out_q <= out` on every rising `clk`.
- Coverage: at each rising `clk`, when `a` and `b` are both known (0 or 1), set `seen[{a,b}]`. Bits never clear except on reset.
- Self-check: at each rising `clk`, when the inputs are known and `out !== (a | b)`, set `mismatch`. It stays set until reset.
- Reset (`rst`=1 at a rising `clk`):
  - `out_q` = 0, `seen` = 4'b0000, `mismatch` = 0.
  - The same edge performs no coverage or check update.
- Reset has no effect on `out`, which stays purely combinational.

## Timing
- `out`: zero-delay combinational; settles in the same simulation time step as an input change.
- `out_q`, `seen`, `mismatch`: 1-cycle latency. They reflect the inputs sampled at the last rising edge.
- Inputs changing mid-cycle affect only `out`. Clocked outputs see the value present at the edge.
- Reset asserted mid-operation: clocked outputs clear at the next rising edge. Sampling resumes on the first edge with `rst`=0.
- Reset and an input change on the same edge: reset wins.

## Structure
- Sub-module `or_gate_cmos`: pure switch-level core with ports `a`, `b`, `out` and no clock. It is instantiated once. The wrapper holds the register, coverage and check logic.
- Shared package `digital_design_pkg`: constant `OR_COMBOS` = 4 and a typedef for the 4-bit coverage vector. No other shared items.
- Synthesis note: the transistor primitives are simulation-only. A synthesis build substitutes `assign out = a | b;` inside `or_gate_cmos` under a `` `ifdef SYNTHESIS `` guard.

## Test plan
- Truth sweep:
  - Stimulus: 10 ns clock, `rst`=1 for one cycle, then apply ab = 00, 10, 01, 11 in turn, each held 10 ns.
  - Required response: `out` = 0, 1, 1, 1; `out_q` follows one edge later.
  - Final state: `seen` = 4'b1111, `mismatch` = 0.
- Reset clear:
  - Stimulus: after the sweep, assert `rst` for one edge.
  - Required response: `out_q` = 0, `seen` = 0, `mismatch` = 0, while `out` still equals the current `a | b`.
- Partial coverage:
  - Stimulus: apply only ab = 00 and 11 across 3 edges.
  - Required response: `seen` = 4'b1001.
- Mid-cycle glitch:
  - Stimulus: toggle `a` 0→1→0 between two edges with `b`=0.
  - Required response: `out` pulses high; `out_q` stays 0; `seen[2]` stays 0.
- Unknown input:
  - Stimulus: drive `a`=X, `b`=0 across an edge.
  - Required response: no `seen` bit set, `mismatch` stays 0.
  - Then drive `a`=X, `b`=1: `out` = 1.
- Fault injection:
  - Stimulus: force the core `out` to 0 with ab = 11 across an edge.
  - Required response: `mismatch` = 1 next cycle and it remains 1 after the force is released, until `rst`.
